imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader that writes the instruction memory of the single-cycle RISC-V core. It consumes a byte stream (from the UART receiver) over a valid/ready handshake, parses a length-prefixed, checksummed frame, and assembles little-endian 32-bit instruction words. Each complete word is written into instruction memory at consecutive word addresses. The core is held in reset until a frame loads cleanly.

## Interface
Parameters:
- ADDR_W, 10, instruction memory word-address width; capacity is 2**ADDR_W words.

Ports:
- clk  in  1  system clock; one clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a load; accepted only in IDLE, DONE or ERR.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte this cycle.
- imem_we  out  1  instruction memory write strobe; one cycle per word.
- imem_addr  out  ADDR_W  word address for the write.
- imem_wdata  out  32  instruction word.
- cpu_hold  out  1  holds the core in reset while high.
- done  out  1  frame loaded and checksum matched.
- err  out  1  frame rejected.

## Operation
- Frame format, in byte order:
  - LEN_LO, LEN_HI: 16-bit word count N.
  - 4*N payload bytes, little-endian per word (first byte is bits 7:0).
  - CSUM: XOR of all payload bytes. Length bytes are not included.
- A byte is accepted when in_valid && in_ready. in_ready is registered and is high only in LEN0, LEN1, DATA and CSUM.
- States and transitions:
  - IDLE: start -> LEN0. Clear done and err, set cpu_hold=1, word index=0, byte index=0, checksum=0.
  - LEN0: on accept, latch low byte -> LEN1.
  - LEN1: on accept, latch high byte. Then:
    - N > 2**ADDR_W -> ERR.
    - N == 0 -> CSUM.
    - otherwise -> DATA.
  - DATA: on each accept, shift the byte into its lane and XOR it into the checksum. On the 4th byte:
    - issue the word write, increment the word index, reset the byte index;
    - if word index + 1 == N -> CSUM.
  - CSUM: on accept, compare the byte with the checksum. Match -> DONE (done=1, cpu_hold=0). Mismatch -> ERR (err=1, cpu_hold=1).
  - DONE / ERR: idle with in_ready=0; start -> LEN0 with the same clearing as IDLE.
- start in LEN0, LEN1, DATA or CSUM is ignored.
- Width rules:
  - The word index counter is ADDR_W+1 bits, so N == 2**ADDR_W is legal.
  - imem_addr is the low ADDR_W bits of the index.
  - N is compared at full 16 bits.
- Memory writes from an errored frame that landed before the error are not undone. cpu_hold stays high, so the core never runs a partial image.

## Timing
- Reset values: state=IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, done=0, err=0.
- in_ready rises the cycle after start. The loader accepts one byte per cycle while in_valid is held high.
- Write latency: imem_we is registered and asserted the cycle after the 4th byte of a word is accepted. It is high for exactly one cycle, with imem_addr and imem_wdata valid in that same cycle.
- done/err and cpu_hold update the cycle after the CSUM byte is accepted. in_ready falls in that same cycle.
- Back-to-back: the last data byte and the CSUM byte may arrive on consecutive cycles. The final word write and the DONE transition may coincide; the write still occurs.
- Reset mid-frame (rst_n low) returns all outputs to their reset values immediately. Any pending write is dropped.

## Structure
- Shared package loader_pkg:
  - state enum: IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR;
  - LEN_BYTES=2, BYTES_PER_WORD=4.
- One sub-module is natural: byte_packer. It holds the 2-bit lane index, the 32-bit shift register and the running XOR checksum, and outputs word_valid. The FSM, counters and handshake stay in imem_loader.

## Test plan
- Frame 01 00 | 13 05 A0 00 | CSUM=B6 -> one write (addr 0, data 0x00A00513), done=1, cpu_hold=0, err=0.
- Frame with N=3, with in_valid toggled every other cycle -> writes at addr 0,1,2 in order, each imem_we exactly one cycle, done=1.
- Frame N=1 with a wrong CSUM (B7) -> the write occurs, then err=1, done=0, cpu_hold=1.
- N=0x0401 with ADDR_W=10 -> ERR after LEN_HI with no writes. N=0x0400 is accepted and 1024 writes are issued (addresses 0..1023).
- N=0 frame 00 00 00 -> done=1 with no writes. A start pulse while in DATA is ignored; the frame completes normally.
- rst_n pulsed low after 2 payload bytes -> all outputs return to reset values, no write, and a fresh start plus a valid frame then loads correctly.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN0 = 3'd1,
    LEN1 = 3'd2,
    DATA = 3'd3,
    CSUM = 3'd4,
    DONE = 3'd5,
    ERR  = 3'd6
  } state_t;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_W         = $clog2(BYTES_PER_WORD);

  // States in which a fresh start pulse is honoured.
  function automatic logic is_restartable(input state_t s);
    return (s == IDLE) || (s == DONE) || (s == ERR);
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs payload bytes into little-endian 32-bit words and keeps the running XOR checksum.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        shift,
  input  logic [7:0]  data,
  output logic        word_valid,
  output logic [31:0] word,
  output logic [7:0]  csum
);

  logic [LANE_W-1:0] lane;
  logic [31:0]       sreg;

  // Bytes enter at the top and move down, so the first byte of a word ends in bits 7:0.
  assign word_valid = shift && (lane == LANE_W'(BYTES_PER_WORD - 1));
  assign word       = {data, sreg[31:8]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane <= '0;
      sreg <= '0;
      csum <= '0;
    end else if (clear) begin
      lane <= '0;
      sreg <= '0;
      csum <= '0;
    end else if (shift) begin
      lane <= lane + 1'b1;
      sreg <= {data, sreg[31:8]};
      csum <= csum ^ data;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed, XOR-checksummed byte frame and writes instruction memory.
// Handshake: a byte transfers on a rising clk edge where in_valid && in_ready; in_ready is registered.
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output state_t            state
);

  logic [ADDR_W:0] word_idx;
  logic [7:0]      len_lo;
  logic [15:0]     len;
  logic [15:0]     len_full;
  logic            accept;
  logic            restart;
  logic            last_word;
  logic            too_long;

  logic            pk_valid;
  logic [31:0]     pk_word;
  logic [7:0]      pk_csum;

  assign accept    = in_valid && in_ready;
  assign restart   = start && is_restartable(state);
  assign len_full  = {in_data, len_lo};
  // Index counter is one bit wider than the address, so a full-memory image is representable.
  assign too_long  = 32'(len_full) > (32'd1 << ADDR_W);
  assign last_word = (32'(word_idx) + 32'd1) == 32'(len);

  byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (restart),
    .shift      (accept && (state == DATA)),
    .data       (in_data),
    .word_valid (pk_valid),
    .word       (pk_word),
    .csum       (pk_csum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      word_idx   <= '0;
      len_lo     <= '0;
      len        <= '0;
    end else begin
      imem_we <= pk_valid;
      if (pk_valid) begin
        imem_addr  <= word_idx[ADDR_W-1:0];
        imem_wdata <= pk_word;
      end

      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state    <= LEN0;
            in_ready <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            cpu_hold <= 1'b1;
            word_idx <= '0;
          end
        end

        LEN0: begin
          if (accept) begin
            len_lo <= in_data;
            state  <= LEN1;
          end
        end

        LEN1: begin
          if (accept) begin
            len <= len_full;
            if (too_long) begin
              state    <= ERR;
              in_ready <= 1'b0;
              err      <= 1'b1;
            end else if (len_full == 16'd0) begin
              state <= CSUM;
            end else begin
              state <= DATA;
            end
          end
        end

        DATA: begin
          if (pk_valid) begin
            word_idx <= word_idx + 1'b1;
            if (last_word) state <= CSUM;
          end
        end

        CSUM: begin
          if (accept) begin
            in_ready <= 1'b0;
            if (in_data == pk_csum) begin
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state    <= ERR;
              err      <= 1'b1;
              cpu_hold <= 1'b1;
            end
          end
        end

        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard fed as words are driven.
module tb_imem_loader;
  import loader_pkg::*;

  localparam int ADDR_W = 10;
  localparam int EW     = ADDR_W + 32;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;
  state_t            state;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err),
    .state      (state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int wr_idx = 0;
  logic [7:0] run_csum;
  logic prev_we = 1'b0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every write must match the oldest expected {addr, data}.
  always @(negedge clk) begin
    if (imem_we) begin
      wr_count++;
      check("we_single_cycle", 64'(prev_we), 64'd0);
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write: observed addr=%0h data=%0h expected no write", imem_addr, imem_wdata);
      end
      if (exp_q.size() != 0) check("write", 64'({imem_addr, imem_wdata}), 64'(exp_q.pop_front()));
    end
    prev_we = imem_we;
  end

  // Driver tasks (called at a negedge, return at a negedge)
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("accept_bound", 64'(t < 100), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int g = 0; g < gap; g++) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wr_idx   = 0;
    run_csum = 8'h00;
  endtask

  task automatic send_len(input logic [15:0] n, input int gap);
    send_byte(n[7:0], gap);
    send_byte(n[15:8], gap);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int b = 0; b < 4; b++) begin
      logic [7:0] bv;
      bv = w[8*b +: 8];
      run_csum = run_csum ^ bv;
      if (b == 3) begin
        logic [ADDR_W-1:0] a;
        a = wr_idx[ADDR_W-1:0];
        exp_q.push_back({a, w});
        wr_idx++;
      end
      send_byte(bv, gap);
    end
  endtask

  task automatic check_end(input string tag, input logic d, input logic e, input logic h);
    check({tag, "_done"}, 64'(done), 64'(d));
    check({tag, "_err"}, 64'(err), 64'(e));
    check({tag, "_hold"}, 64'(cpu_hold), 64'(h));
    check({tag, "_ready"}, 64'(in_ready), 64'd0);
  endtask

  initial begin
    int base;
    rst_n    = 1'b0;
    start    = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    run_csum = 8'h00;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_ready", 64'(in_ready), 64'd0);
    check("rst_we", 64'(imem_we), 64'd0);
    check("rst_addr", 64'(imem_addr), 64'd0);
    check("rst_wdata", 64'(imem_wdata), 64'd0);
    check("rst_hold", 64'(cpu_hold), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_state", 64'(state), 64'(IDLE));
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", 64'(in_ready), 64'd0);

    // Single-word frame with known checksum B6
    base = wr_count;
    pulse_start();
    check("ready_after_start", 64'(in_ready), 64'd1);
    send_len(16'h0001, 0);
    send_word(32'h00A00513, 0);
    check("f1_csum_model", 64'(run_csum), 64'hB6);
    send_byte(8'hB6, 0);
    check_end("f1", 1'b1, 1'b0, 1'b0);
    check("f1_writes", 64'(wr_count - base), 64'd1);

    // N=3, in_valid toggled every other cycle
    base = wr_count;
    pulse_start();
    send_len(16'h0003, 1);
    send_word(32'h11223344, 1);
    send_word(32'hDEADBEEF, 1);
    send_word(32'($urandom), 1);
    send_byte(run_csum, 1);
    check_end("f3", 1'b1, 1'b0, 1'b0);
    check("f3_writes", 64'(wr_count - base), 64'd3);

    // Bad checksum: write still lands, frame rejected
    base = wr_count;
    pulse_start();
    send_len(16'h0001, 0);
    send_word(32'h00A00513, 0);
    send_byte(8'hB7, 0);
    repeat (2) @(negedge clk);
    check_end("bad", 1'b0, 1'b1, 1'b1);
    check("bad_writes", 64'(wr_count - base), 64'd1);

    // Oversized length
    base = wr_count;
    pulse_start();
    send_len(16'h0401, 0);
    check_end("big", 1'b0, 1'b1, 1'b1);
    check("big_state", 64'(state), 64'(ERR));
    repeat (3) @(negedge clk);
    check("big_writes", 64'(wr_count - base), 64'd0);

    // Full-memory image, back-to-back bytes
    base = wr_count;
    pulse_start();
    send_len(16'h0400, 0);
    for (int i = 0; i < 1024; i++) send_word(32'($urandom), 0);
    send_byte(run_csum, 0);
    check_end("full", 1'b1, 1'b0, 1'b0);
    check("full_writes", 64'(wr_count - base), 64'd1024);

    // Empty frame
    base = wr_count;
    pulse_start();
    send_len(16'h0000, 0);
    send_byte(8'h00, 0);
    repeat (2) @(negedge clk);
    check_end("empty", 1'b1, 1'b0, 1'b0);
    check("empty_writes", 64'(wr_count - base), 64'd0);

    // Start pulse in DATA is ignored
    base = wr_count;
    pulse_start();
    send_len(16'h0002, 0);
    run_csum = run_csum ^ 8'h78 ^ 8'h56;
    send_byte(8'h78, 0);
    send_byte(8'h56, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_ignored", 64'(state), 64'(DATA));
    run_csum = run_csum ^ 8'h34 ^ 8'h12;
    send_byte(8'h34, 0);
    exp_q.push_back({ADDR_W'(0), 32'h12345678});
    wr_idx = 1;
    send_byte(8'h12, 0);
    send_word(32'hCAFEF00D, 0);
    send_byte(run_csum, 0);
    check_end("ign", 1'b1, 1'b0, 1'b0);
    check("ign_writes", 64'(wr_count - base), 64'd2);

    // Reset mid-frame
    base = wr_count;
    pulse_start();
    send_len(16'h0001, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 64'(in_ready), 64'd0);
    check("mid_rst_hold", 64'(cpu_hold), 64'd1);
    check("mid_rst_state", 64'(state), 64'(IDLE));
    check("mid_rst_outs", 64'({imem_we, imem_addr, imem_wdata, done, err}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_rst_writes", 64'(wr_count - base), 64'd0);
    pulse_start();
    send_len(16'h0002, 0);
    send_word(32'h00000013, 0);
    send_word(32'h0000006F, 0);
    send_byte(run_csum, 0);
    check_end("post_rst", 1'b1, 1'b0, 1'b0);
    check("post_rst_writes", 64'(wr_count - base), 64'd2);

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
